// File: rtl/seg_disp_ctrl.sv
// 4-digit seven-segment controller: double-dabble BIN->BCD, scan mux, zero blanking.
// Optional SEG_DISP_CTRL_BLINK_EN adds blink_mask and a blink phase counter.
module seg_disp_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int BIN_W   = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
`ifdef SEG_DISP_CTRL_BLINK_EN
  input  logic [3:0]       blink_mask,
`endif
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic [3:0]       anode,
  output logic [3:0]       num,
  output logic             scan_tick
);

  localparam int ITW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [BIN_W-1:0] val_q;
  logic [BIN_W-1:0] sh_q;
  logic [15:0]      sc_q;
  logic [15:0]      adj;
  logic [ITW-1:0]   it_q;
  logic             last_it;

  logic [3:0]       ones_q;
  logic [3:0]       tens_q;
  logic [3:0]       hund_q;
  logic [3:0]       thou_q;
  logic             ovf_q;

  assign last_it = (it_q == ITW'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (last_it) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // add-3 correction applied before every shift
  always_comb begin
    adj = sc_q;
    for (int i = 0; i < 4; i++) begin
      if (sc_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = sc_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      sh_q    <= '0;
      sc_q    <= '0;
      it_q    <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
      thou_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            val_q <= bin_in;
            sh_q  <= bin_in;
            sc_q  <= '0;
            it_q  <= '0;
          end
        end
        CONV: begin
          sc_q <= {adj[14:0], sh_q[BIN_W-1]};
          sh_q <= sh_q << 1;
          it_q <= it_q + ITW'(1);
        end
        COMMIT: begin
          if (32'(val_q) > 32'd9999) begin
            ovf_q  <= 1'b1;
            ones_q <= 4'hF;
            tens_q <= 4'hF;
            hund_q <= 4'hF;
            thou_q <= 4'hF;
          end else begin
            ovf_q  <= 1'b0;
            ones_q <= sc_q[3:0];
            tens_q <= sc_q[7:4];
            hund_q <= sc_q[11:8];
            thou_q <= sc_q[15:12];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;
  assign ones      = ones_q;
  assign tens      = tens_q;
  assign hundreds  = hund_q;
  assign thousands = thou_q;

  logic [PW-1:0] pre_q;
  logic [1:0]    slot_q;
  logic [3:0]    anode_q;
  logic [3:0]    num_q;
  logic          tick_q;
  logic          wrap;
  logic          lz1;
  logic          lz2;
  logic          lz3;
  logic [3:0]    dig;
  logic [3:0]    an_sel;
  logic          blk;

  assign wrap = (pre_q == PW'(CLK_DIV - 1));
  assign lz3  = !ovf_q && (thou_q == 4'd0);
  assign lz2  = lz3 && (hund_q == 4'd0);
  assign lz1  = lz2 && (tens_q == 4'd0);

`ifdef SEG_DISP_CTRL_BLINK_EN
  logic [8:0] bcnt_q;
  logic       blink_blk;

  assign blink_blk = bcnt_q[8] && blink_mask[slot_q];

  always_ff @(posedge clk) begin
    if (rst)
      bcnt_q <= '0;
    else if (wrap)
      bcnt_q <= bcnt_q + 9'd1;
  end
`else
  logic blink_blk;
  assign blink_blk = 1'b0;
`endif

  always_comb begin
    dig    = ones_q;
    an_sel = 4'b1110;
    blk    = 1'b0;
    unique case (slot_q)
      2'd0: begin
        dig    = ones_q;
        an_sel = 4'b1110;
        blk    = 1'b0;
      end
      2'd1: begin
        dig    = tens_q;
        an_sel = 4'b1101;
        blk    = lz1;
      end
      2'd2: begin
        dig    = hund_q;
        an_sel = 4'b1011;
        blk    = lz2;
      end
      2'd3: begin
        dig    = thou_q;
        an_sel = 4'b0111;
        blk    = lz3;
      end
      default: ;
    endcase
  end

  // slot outputs latch the pre-advance slot using digits as they stand now
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      slot_q  <= 2'd0;
      anode_q <= 4'b1111;
      num_q   <= 4'd0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (wrap) begin
        pre_q   <= '0;
        slot_q  <= slot_q + 2'd1;
        anode_q <= (blk || blink_blk) ? 4'b1111 : an_sel;
        num_q   <= dig;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

  assign anode     = anode_q;
  assign num       = num_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl at CLK_DIV=4, BIN_W=14.
// Each task drives one scenario and compares inline against hand values.
module tb_seg_disp_ctrl;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        load;
  logic        busy;
  logic        ovf;
  logic [3:0]  ones;
  logic [3:0]  tens;
  logic [3:0]  hundreds;
  logic [3:0]  thousands;
  logic [3:0]  anode;
  logic [3:0]  num;
  logic        scan_tick;

  int nvec = 0;
  int nerr = 0;

  seg_disp_ctrl #(.CLK_DIV(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .load      (load),
    .busy      (busy),
    .ovf       (ovf),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .anode     (anode),
    .num       (num),
    .scan_tick (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [13:0] v, output int bcyc);
    @(negedge clk);
    bin_in = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 40) begin
      bcyc++;
      @(negedge clk);
    end
  endtask

  // collects one full scan round starting at slot 0; no comparisons here
  task automatic capture_scan(output logic [15:0] an, output logic [15:0] nm,
                              output logic ok, output logic stable);
    int n;
    an     = '1;
    nm     = '0;
    stable = 1'b1;
    repeat (20) @(negedge clk);
    n = 0;
    while (!(scan_tick && anode == 4'b1110) && n < 40) begin
      n++;
      @(negedge clk);
    end
    ok = (n < 40);
    for (int s = 0; s < 4; s++) begin
      an[s*4 +: 4] = anode;
      nm[s*4 +: 4] = num;
      for (int k = 0; k < 4; k++) begin
        if (anode !== an[s*4 +: 4] || num !== nm[s*4 +: 4]) stable = 1'b0;
        if (scan_tick !== (k == 0)) stable = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    load   = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy, ovf} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_flags got=%b want=00", {busy, ovf});
    end
    nvec++;
    if ({thousands, hundreds, tens, ones} !== 16'h0000) begin
      nerr++;
      $display("FAIL reset_digits got=%h want=0000",
               {thousands, hundreds, tens, ones});
    end
    nvec++;
    if ({anode, num, scan_tick} !== {4'b1111, 4'h0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_scan got=%b/%h/%b want=1111/0/0",
               anode, num, scan_tick);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_convert;
    int b;
    logic [15:0] an, nm;
    logic ok, st;
    do_load(14'd1234, b);
    nvec++;
    if (b != 15) begin
      nerr++;
      $display("FAIL busy_len_1234 got=%0d want=15", b);
    end
    nvec++;
    if ({ovf, thousands, hundreds, tens, ones} !== {1'b0, 16'h1234}) begin
      nerr++;
      $display("FAIL digits_1234 got=%b/%h want=0/1234",
               ovf, {thousands, hundreds, tens, ones});
    end
    capture_scan(an, nm, ok, st);
    nvec++;
    if ({ok, st, an, nm} !== {2'b11, 16'b0111_1011_1101_1110, 16'h1234}) begin
      nerr++;
      $display("FAIL scan_1234 got=%b%b %b %h want=11 0111101111011110 1234",
               ok, st, an, nm);
    end
  endtask

  task automatic test_blanking;
    int b;
    logic [15:0] an, nm;
    logic ok, st;
    do_load(14'd7, b);
    capture_scan(an, nm, ok, st);
    nvec++;
    if ({ok, st, an, nm} !== {2'b11, 16'b1111_1111_1111_1110, 16'h0007}) begin
      nerr++;
      $display("FAIL scan_7 got=%b%b %b %h want=11 1111111111111110 0007",
               ok, st, an, nm);
    end
    do_load(14'd0, b);
    capture_scan(an, nm, ok, st);
    nvec++;
    if ({ok, st, an, nm} !== {2'b11, 16'b1111_1111_1111_1110, 16'h0000}) begin
      nerr++;
      $display("FAIL scan_0 got=%b%b %b %h want=11 1111111111111110 0000",
               ok, st, an, nm);
    end
    do_load(14'd1005, b);
    nvec++;
    if ({thousands, hundreds, tens, ones} !== 16'h1005) begin
      nerr++;
      $display("FAIL digits_1005 got=%h want=1005",
               {thousands, hundreds, tens, ones});
    end
    capture_scan(an, nm, ok, st);
    nvec++;
    if ({ok, st, an, nm} !== {2'b11, 16'b0111_1011_1101_1110, 16'h1005}) begin
      nerr++;
      $display("FAIL scan_1005 got=%b%b %b %h want=11 0111101111011110 1005",
               ok, st, an, nm);
    end
  endtask

  task automatic test_overflow;
    int b;
    logic [15:0] an, nm;
    logic ok, st;
    do_load(14'd10000, b);
    nvec++;
    if (b != 15 || {ovf, thousands, hundreds, tens, ones} !== {1'b1, 16'hFFFF}) begin
      nerr++;
      $display("FAIL ovf_10000 got=%0d %b/%h want=15 1/ffff",
               b, ovf, {thousands, hundreds, tens, ones});
    end
    capture_scan(an, nm, ok, st);
    nvec++;
    if ({ok, st, an, nm} !== {2'b11, 16'b0111_1011_1101_1110, 16'hFFFF}) begin
      nerr++;
      $display("FAIL scan_ovf got=%b%b %b %h want=11 0111101111011110 ffff",
               ok, st, an, nm);
    end
  endtask

  task automatic test_back_to_back;
    int b;
    logic [15:0] mid;
    mid = '0;
    @(negedge clk);
    bin_in = 14'd4321;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    b = 0;
    while (busy && b < 40) begin
      b++;
      if (b == 5) begin
        bin_in = 14'd9999;
        load   = 1'b1;
        mid    = {thousands, hundreds, tens, ones};
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    nvec++;
    if (mid !== 16'hFFFF) begin
      nerr++;
      $display("FAIL stable_during_conv got=%h want=ffff", mid);
    end
    nvec++;
    if (b != 15 || {ovf, thousands, hundreds, tens, ones} !== {1'b0, 16'h4321}) begin
      nerr++;
      $display("FAIL ignore_load got=%0d %b/%h want=15 0/4321",
               b, ovf, {thousands, hundreds, tens, ones});
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL no_queue got=%b want=0", busy);
    end
    do_load(14'd9999, b);
    nvec++;
    if ({ovf, thousands, hundreds, tens, ones} !== {1'b0, 16'h9999}) begin
      nerr++;
      $display("FAIL digits_9999 got=%b/%h want=0/9999",
               ovf, {thousands, hundreds, tens, ones});
    end
  endtask

  task automatic test_reset_abort;
    int b;
    logic [15:0] an, nm;
    logic ok, st;
    @(negedge clk);
    bin_in = 14'd1234;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    b = 0;
    while (busy && b < 7) begin
      b++;
      if (b < 7) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({busy, thousands, hundreds, tens, ones, anode, scan_tick} !==
        {1'b0, 16'h0000, 4'b1111, 1'b0}) begin
      nerr++;
      $display("FAIL reset_abort got=%b %h %b %b want=0 0000 1111 0",
               busy, {thousands, hundreds, tens, ones}, anode, scan_tick);
    end
    do_load(14'd42, b);
    nvec++;
    if (b != 15 || {ovf, thousands, hundreds, tens, ones} !== {1'b0, 16'h0042}) begin
      nerr++;
      $display("FAIL digits_42 got=%0d %b/%h want=15 0/0042",
               b, ovf, {thousands, hundreds, tens, ones});
    end
    capture_scan(an, nm, ok, st);
    nvec++;
    if ({ok, st, an, nm} !== {2'b11, 16'b1111_1111_1101_1110, 16'h0042}) begin
      nerr++;
      $display("FAIL scan_42 got=%b%b %b %h want=11 1111111111011110 0042",
               ok, st, an, nm);
    end
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    bin_in = '0;
    test_reset;
    test_convert;
    test_blanking;
    test_overflow;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
